// File: rtl/rshp_pkg.sv
// Shared types for the reshaper sequencer: FSM state, output-queue entry,
// error bit positions and the byte-lane mask helper.
// The queue entry is sized from RSHP_DW / RSHP_BW; rshp_seq's DW must match.
package rshp_pkg;

  localparam int RSHP_DW = 512;
  localparam int RSHP_NB = RSHP_DW / 8;
  localparam int RSHP_BW = $clog2(RSHP_NB) + 1;
  localparam int RSHP_LW = 24;

  // Bit positions inside err[1:0]
  localparam int ERR_CFG = 1;
  localparam int ERR_OVF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rshp_state_e;

  typedef struct packed {
    logic [RSHP_DW-1:0] data;
    logic [RSHP_BW-1:0] nbyte;
    logic               last;
  } oq_entry_t;

  // All-ones in the byte lanes below nbyte, zero above.
  function automatic logic [RSHP_DW-1:0] byte_mask(input logic [RSHP_BW-1:0] nbyte);
    logic [RSHP_DW-1:0] m;
    m = '0;
    for (int i = 0; i < RSHP_NB; i++) begin
      if (i < int'(nbyte)) m[8*i +: 8] = 8'hff;
    end
    return m;
  endfunction

endpackage

// File: rtl/rshp_oq.sv
// Two-entry output queue for rshp_seq. Entry 0 is always the head so the
// m_* outputs come straight from a register.
// Optional feature macro: RSHP_SEQ_ZMASK_EN zeroes byte lanes at index >= nbyte
// when an entry is pushed.
module rshp_oq
  import rshp_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      clr,
  input  logic      push,
  input  oq_entry_t push_ent,
  input  logic      pop,
  output oq_entry_t head,
  output logic [1:0] cnt
);

  oq_entry_t ent0;
  oq_entry_t ent1;
  oq_entry_t pe;

  // Entry as stored: optionally masked above its byte count.
  always_comb begin
    pe = push_ent;
`ifdef RSHP_SEQ_ZMASK_EN
    pe.data = push_ent.data & byte_mask(push_ent.nbyte);
`else
    pe.data = push_ent.data;
`endif
  end

  // Shift-style queue: pop moves entry 1 into the head slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= pe;
          else             ent1 <= pe;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= pe;
          end else begin
            ent0 <= ent1;
            ent1 <= pe;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/rshp_seq.sv
// Reshaper sequencer: writes variable-size input beats into the byte FIFO and
// reads fixed-size output beats back out for one frame of cfg_total bytes.
// Optional feature macro: RSHP_SEQ_ZMASK_EN (zero m_data lanes >= m_byte).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the source holds its payload
// stable while valid is high and ready is low.
module rshp_seq
  import rshp_pkg::*;
#(
  parameter int DW = RSHP_DW,
  parameter int LW = RSHP_LW,
  localparam int NB = DW / 8,
  localparam int BW = $clog2(NB) + 1,
  localparam int VW = $clog2(2 * NB) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_start,
  input  logic          cfg_abort,
  input  logic [LW-1:0] cfg_total,
  input  logic [BW-1:0] cfg_obyte,
  input  logic          s_vld,
  output logic          s_rdy,
  input  logic [BW-1:0] s_byte,
  input  logic [DW-1:0] s_data,
  output logic          m_vld,
  input  logic          m_rdy,
  output logic [BW-1:0] m_byte,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic          ffwreq,
  output logic [BW-1:0] ffwbyte,
  output logic [DW-1:0] ffwdata,
  output logic          ffrreq,
  output logic [BW-1:0] ffrbyte,
  input  logic [DW-1:0] ffrdata,
  input  logic          ffrvld,
  input  logic [VW-1:0] ffvbyte,
  input  logic          ffwfull,
  output rshp_state_e   dbg_state,
  output logic [1:0]    dbg_qcnt
);

  rshp_state_e   state;
  logic [LW-1:0] in_rem;
  logic [LW-1:0] out_rem_issue;
  logic [BW-1:0] obyte;
  logic          inflight;
  logic [BW-1:0] inflight_byte;
  logic          inflight_last;

  logic [LW-1:0] s_byte_l;
  logic [LW-1:0] wr_len;
  logic [LW-1:0] rd_len;
  logic [VW-1:0] flush_len;
  logic [2:0]    slot_use;
  logic          run_go;
  logic          pop;
  logic          rd_req_run;
  logic          rd_req_flush;
  logic          oq_clr;
  logic          oq_push;
  oq_entry_t     push_ent;
  oq_entry_t     head;
  logic [1:0]    q_cnt;

  assign run_go   = (state == RUN) && !cfg_abort;
  assign pop      = m_vld & m_rdy;

  // Write side: clip each beat to the bytes the frame still needs.
  assign s_byte_l = LW'(s_byte);
  assign wr_len   = (s_byte_l > in_rem) ? in_rem : s_byte_l;
  assign s_rdy    = run_go && !ffwfull && (in_rem != '0);
  assign ffwreq   = s_vld & s_rdy;
  assign ffwbyte  = BW'(wr_len);
  assign ffwdata  = s_data;

  // Read side: only issue when the queue will have room once the read lands.
  assign rd_len       = (LW'(obyte) < out_rem_issue) ? LW'(obyte) : out_rem_issue;
  assign slot_use     = 3'(q_cnt) + 3'(inflight) - 3'(pop);
  assign rd_req_run   = run_go && (out_rem_issue != '0) &&
                        (LW'(ffvbyte) >= rd_len) && (slot_use < 3'd2);
  assign flush_len    = (ffvbyte > VW'(NB)) ? VW'(NB) : ffvbyte;
  assign rd_req_flush = (state == FLUSH) && (ffvbyte != '0) && !inflight;
  assign ffrreq       = rd_req_run | rd_req_flush;
  assign ffrbyte      = (state == FLUSH) ? BW'(flush_len) : BW'(rd_len);

  // Frame FSM, byte counters, error flags and the in-flight read tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      in_rem        <= '0;
      out_rem_issue <= '0;
      obyte         <= '0;
      err           <= 2'b00;
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_byte <= '0;
      inflight_last <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= ffrreq;
      inflight_byte <= ffrbyte;
      inflight_last <= rd_req_run && (rd_len == out_rem_issue);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if ((cfg_obyte != '0) && (cfg_obyte <= BW'(NB)) && (cfg_total != '0)) begin
              state         <= RUN;
              in_rem        <= cfg_total;
              out_rem_issue <= cfg_total;
              obyte         <= cfg_obyte;
              err           <= 2'b00;
            end else begin
              err          <= 2'b00;
              err[ERR_CFG] <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cfg_abort) begin
            state <= FLUSH;
          end else begin
            if (ffwreq) begin
              in_rem <= in_rem - wr_len;
              if (s_byte_l > in_rem) err[ERR_OVF] <= 1'b1;
            end
            if (rd_req_run) out_rem_issue <= out_rem_issue - rd_len;
            if (pop && m_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if ((ffvbyte == '0) && !inflight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data returns one cycle after the request with the tag captured then.
  always_comb begin
    push_ent       = '0;
    push_ent.data  = ffrdata;
    push_ent.nbyte = inflight_byte;
    push_ent.last  = inflight_last;
  end

  assign oq_clr  = !run_go;
  assign oq_push = ffrvld && run_go;

  rshp_oq u_oq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (oq_clr),
    .push     (oq_push),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .cnt      (q_cnt)
  );

  assign m_vld     = (q_cnt != 2'd0);
  assign m_data    = head.data;
  assign m_byte    = head.nbyte;
  assign m_last    = head.last;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_qcnt  = q_cnt;

endmodule

// File: tb/tb_rshp_seq.sv
// Bench for rshp_seq: byte-queue FIFO model on the FIFO ports, random beats,
// and a byte-stream reference (output = first cfg_total input bytes cut into
// cfg_obyte pieces).
module tb_rshp_seq;
  import rshp_pkg::*;

  localparam int DW = 512;
  localparam int LW = 24;
  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam int VW = $clog2(2 * NB) + 1;

  logic          clk;
  logic          reset_n;
  logic          cfg_start;
  logic          cfg_abort;
  logic [LW-1:0] cfg_total;
  logic [BW-1:0] cfg_obyte;
  logic          s_vld;
  logic          s_rdy;
  logic [BW-1:0] s_byte;
  logic [DW-1:0] s_data;
  logic          m_vld;
  logic          m_rdy;
  logic [BW-1:0] m_byte;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic          ffwreq;
  logic [BW-1:0] ffwbyte;
  logic [DW-1:0] ffwdata;
  logic          ffrreq;
  logic [BW-1:0] ffrbyte;
  logic [DW-1:0] ffrdata;
  logic          ffrvld;
  logic [VW-1:0] ffvbyte;
  logic          ffwfull;
  rshp_state_e   dbg_state;
  logic [1:0]    dbg_qcnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         beat_q[$];
  int         exp_rem;
  int         exp_in_rem;
  int         exp_obyte;
  bit         exp_ovf;
  int         last_wbyte;

  // FIFO model state
  logic [7:0]    fifo_q[$];
  int            fifo_bad = 0;
  logic [DW-1:0] rd_word;

  rshp_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_total(cfg_total), .cfg_obyte(cfg_obyte),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_byte(s_byte), .s_data(s_data),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_byte(m_byte), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err),
    .ffwreq(ffwreq), .ffwbyte(ffwbyte), .ffwdata(ffwdata),
    .ffrreq(ffrreq), .ffrbyte(ffrbyte), .ffrdata(ffrdata), .ffrvld(ffrvld),
    .ffvbyte(ffvbyte), .ffwfull(ffwfull),
    .dbg_state(dbg_state), .dbg_qcnt(dbg_qcnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte FIFO: reads take effect before writes, read data valid next cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q.delete();
      ffrvld  <= 1'b0;
      ffrdata <= '0;
      ffvbyte <= '0;
    end else begin
      rd_word = {16{$urandom()}};
      if (ffrreq) begin
        for (int i = 0; i < int'(ffrbyte); i++) begin
          if (fifo_q.size() == 0) fifo_bad++;
          else rd_word[8*i +: 8] = fifo_q.pop_front();
        end
      end
      if (ffwreq) begin
        for (int i = 0; i < int'(ffwbyte); i++) fifo_q.push_back(ffwdata[8*i +: 8]);
      end
      if (fifo_q.size() > 2 * NB) fifo_bad++;
      ffrvld  <= ffrreq;
      ffrdata <= rd_word;
      ffvbyte <= VW'(fifo_q.size());
    end
  end

  assign ffwfull = (ffvbyte > VW'(NB));

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic start_frame(input int total, input int obyte);
    exp_q.delete();
    exp_rem    = total;
    exp_in_rem = total;
    exp_obyte  = obyte;
    exp_ovf    = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_total = LW'(total);
    cfg_obyte = BW'(obyte);
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic fill_beats(input int total);
    int sum = 0;
    int n;
    beat_q.delete();
    while (sum < total) begin
      n = $urandom_range(1, NB);
      beat_q.push_back(n);
      sum += n;
    end
  endtask

  task automatic send_beats();
    int  n;
    int  take;
    bit  ok;
    logic [DW-1:0] d;
    while (beat_q.size() != 0) begin
      n = beat_q.pop_front();
      for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom());
      @(posedge clk); #1;
      s_vld  = 1'b1;
      s_byte = BW'(n);
      s_data = d;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (s_rdy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        check("s_timeout", 0, 1);
        beat_q.delete();
      end else begin
        last_wbyte = int'(ffwbyte);
        take = (n > exp_in_rem) ? exp_in_rem : n;
        if (n > exp_in_rem) exp_ovf = 1'b1;
        for (int i = 0; i < take; i++) exp_q.push_back(d[8*i +: 8]);
        exp_in_rem -= take;
      end
    end
    @(posedge clk); #1;
    s_vld = 1'b0;
  endtask

  // Scoreboard: compare one accepted output beat against the byte stream.
  task automatic check_beat(output bit is_last);
    int            sz;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] mask;
    sz = (exp_obyte < exp_rem) ? exp_obyte : exp_rem;
    exp_d = '0;
    mask  = '0;
    for (int i = 0; i < sz; i++) begin
      mask[8*i +: 8] = 8'hff;
      if (exp_q.size() != 0) exp_d[8*i +: 8] = exp_q.pop_front();
    end
    exp_rem -= sz;
    is_last = (exp_rem == 0);
    check("m_byte", m_byte, sz);
    check("m_last", m_last, is_last);
`ifdef RSHP_SEQ_ZMASK_EN
    check("m_data", m_data, exp_d);
`else
    check("m_data", m_data & mask, exp_d);
`endif
  endtask

  task automatic recv_frame(input int mode);
    int stall_left = 20;
    int beats = 0;
    bit fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       m_rdy = 1'b1;
        1:       m_rdy = 1'($urandom_range(0, 1));
        default: m_rdy = !(beats == 1 && stall_left > 0);
      endcase
      @(negedge clk);
      if (mode == 2 && beats == 1 && stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          check("stall_qcnt", dbg_qcnt, 2);
          check("stall_ffrreq", ffrreq, 0);
          check("stall_s_rdy", s_rdy, 0);
          check("stall_ffv_gt_nb", ffvbyte > VW'(NB), 1);
        end
      end
      if (m_vld && m_rdy) begin
        check_beat(fin);
        beats++;
      end
    end
    if (!fin) check("recv_timeout", 0, 1);
    @(posedge clk); #1;
    m_rdy = 1'b0;
  endtask

  task automatic run_frame(input int total, input int obyte, input int mode);
    start_frame(total, obyte);
    fork
      send_beats();
      recv_frame(mode);
    join
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("err_end", err, {1'b0, exp_ovf});
    check("bytes_left", exp_q.size(), 0);
    @(negedge clk);
    check("done_once", done, 0);
  endtask

  task automatic bad_start(input int total, input int obyte);
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_total = LW'(total);
    cfg_obyte = BW'(obyte);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    check("cfg_err", err, 2'b10);
    check("cfg_busy", busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_m_vld"}, m_vld, 0);
    check({tag, "_s_rdy"}, s_rdy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ffrreq"}, ffrreq, 0);
    check({tag, "_ffwreq"}, ffwreq, 0);
    check({tag, "_state"}, dbg_state, IDLE);
    check({tag, "_qcnt"}, dbg_qcnt, 0);
  endtask

  initial begin
    int rd_seen[$];
    bit saw_done;
    bit saw_mvld;
    reset_n   = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_total = '0;
    cfg_obyte = '0;
    s_vld     = 1'b0;
    s_byte    = '0;
    s_data    = '0;
    m_rdy     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reference frame: 200 bytes in 48-byte pieces
    beat_q = '{64, 64, 64, 8};
    run_frame(200, 48, 0);

    // Oversized final beat is clipped to 2 bytes
    beat_q = '{64, 64, 64};
    run_frame(130, 64, 0);
    check("ovf_wbyte", last_wbyte, 2);

    // Output stall mid-frame
    beat_q = '{64, 64, 64, 64, 64, 64, 64, 64, 64, 64};
    run_frame(640, 64, 2);

    // Bad configurations
    bad_start(100, 0);
    bad_start(100, 65);
    bad_start(0, 32);

    // Abort with 100 bytes left in the FIFO
    start_frame(1000, 64);
    beat_q = '{64, 64, 64, 36};
    send_beats();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_ffv", ffvbyte, 100);
    check("abort_qcnt", dbg_qcnt, 2);
    @(posedge clk); #1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    saw_done = 1'b0;
    saw_mvld = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ffrreq) rd_seen.push_back(int'(ffrbyte));
      if (done) saw_done = 1'b1;
      if (m_vld) saw_mvld = 1'b1;
      if (!busy) break;
    end
    check("flush_nreads", rd_seen.size(), 2);
    check("flush_rd0", (rd_seen.size() > 0) ? rd_seen[0] : -1, 64);
    check("flush_rd1", (rd_seen.size() > 1) ? rd_seen[1] : -1, 36);
    check("flush_busy", busy, 0);
    check("flush_ffv", ffvbyte, 0);
    check("flush_no_done", saw_done, 0);
    check("flush_no_mvld", saw_mvld, 0);
    fill_beats(200);
    run_frame(200, 48, 1);

    // Reset in the middle of a frame
    start_frame(300, 32);
    beat_q = '{64, 64};
    send_beats();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    fill_beats(300);
    run_frame(300, 32, 1);

    // Edge sizes
    beat_q = '{64};
    run_frame(1, 64, 0);
    beat_q = '{64};
    run_frame(64, 64, 1);
    beat_q = '{5, 7};
    run_frame(12, 1, 1);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      int tot;
      int ob;
      tot = $urandom_range(1, 700);
      ob  = $urandom_range(1, NB);
      fill_beats(tot);
      run_frame(tot, ob, $urandom_range(0, 1));
    end

    check("fifo_model_ok", fifo_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
